// File: rtl/multicycle_control_unit.sv
// Moore-FSM control unit for a multicycle RV32I datapath.
// It steps each instruction through 3-5 states and waits on memory-ready during fetch, load and store.
// Unsupported opcodes trap, and the unit counts retired instructions.
module multicycle_control_unit #(
  parameter int ALU_CTRL_W        = 3,
  parameter bit HAS_MEM_HANDSHAKE = 1'b1,
  parameter int INSTRET_W         = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [6:0]            op,
  input  logic [2:0]            funct3,
  input  logic [6:0]            funct7,
  input  logic                  zero,
  input  logic                  mem_ready,
  output logic                  pc_write,
  output logic                  adr_src,
  output logic                  mem_write,
  output logic                  ir_write,
  output logic [1:0]            result_src,
  output logic [1:0]            alu_src_a,
  output logic [1:0]            alu_src_b,
  output logic [1:0]            imm_src,
  output logic                  reg_write,
  output logic [ALU_CTRL_W-1:0] alu_control,
  output logic                  illegal,
  output logic [INSTRET_W-1:0]  instret
);

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
    S_EXECR, S_EXECI, S_ALUWB, S_BEQ, S_JAL, S_TRAP
  } state_t;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  state_t                 r_state;
  state_t                 w_next;
  state_t                 w_out_state;
  logic [INSTRET_W-1:0]   r_instret;
  logic                   w_mem_ready;
  logic                   w_supported;
  logic                   w_retire;
  logic [1:0]             w_alu_op;
  logic [2:0]             w_alu_ctrl;
  logic                   w_pc_write;
  logic                   w_ir_write;
  logic                   w_mem_write;
  logic                   w_reg_write;
  logic                   w_unused;

  // Only funct7[5] selects between add and sub. The other funct7 bits are not used.
  assign w_unused    = ^{funct7[6], funct7[4:0]};
  assign w_mem_ready = HAS_MEM_HANDSHAKE ? mem_ready : 1'b1;
  assign w_supported = (op == OP_LW) || (op == OP_SW) || (op == OP_R) ||
                       (op == OP_I)  || (op == OP_BEQ) || (op == OP_JAL);
  // While reset is held, the outputs show the FETCH values.
  assign w_out_state = rst ? S_FETCH : r_state;

  // State register and retired-instruction counter. Reset wins over every transition.
  // NOTE: sequential state uses non-blocking (<=) so that every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_FETCH;
      r_instret <= '0;
    end else begin
      r_state <= w_next;
      if (w_retire) r_instret <= r_instret + INSTRET_W'(1);
    end
  end

  // Next-state logic, plus the retire strobe that fires on the edge leaving a final state.
  // NOTE: defaults are assigned first so that no path leaves a variable unassigned (no latch).
  always_comb begin
    w_next   = r_state;
    w_retire = 1'b0;
    case (r_state)
      S_FETCH:    if (w_mem_ready) w_next = w_supported ? S_DECODE : S_TRAP;
      S_DECODE: begin
        case (op)
          OP_LW, OP_SW: w_next = S_MEMADR;
          OP_R:         w_next = S_EXECR;
          OP_I:         w_next = S_EXECI;
          OP_BEQ:       w_next = S_BEQ;
          OP_JAL:       w_next = S_JAL;
          default:      w_next = S_TRAP;
        endcase
      end
      S_MEMADR:   w_next = (op == OP_SW) ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD:  if (w_mem_ready) w_next = S_MEMWB;
      S_MEMWRITE: begin
        if (w_mem_ready) begin
          w_next   = S_FETCH;
          w_retire = 1'b1;
        end
      end
      S_MEMWB, S_ALUWB, S_BEQ: begin
        w_next   = S_FETCH;
        w_retire = 1'b1;
      end
      S_EXECR, S_EXECI: w_next = S_ALUWB;
      S_JAL:      w_next = S_ALUWB;
      S_TRAP:     w_next = S_TRAP;
      default:    w_next = S_FETCH;
    endcase
  end

  // Moore outputs for each state. Selects that a state does not list stay 0.
  always_comb begin
    w_pc_write  = 1'b0;
    w_ir_write  = 1'b0;
    w_mem_write = 1'b0;
    w_reg_write = 1'b0;
    adr_src     = 1'b0;
    result_src  = 2'b00;
    alu_src_a   = 2'b00;
    alu_src_b   = 2'b00;
    w_alu_op    = 2'b00;
    illegal     = 1'b0;
    case (w_out_state)
      S_FETCH: begin
        alu_src_b  = 2'b10;
        result_src = 2'b10;
        w_ir_write = w_mem_ready;
        w_pc_write = w_mem_ready;
      end
      S_DECODE: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
      end
      S_MEMADR: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
      end
      S_MEMREAD:  adr_src = 1'b1;
      S_MEMWB: begin
        result_src  = 2'b01;
        w_reg_write = 1'b1;
      end
      S_MEMWRITE: begin
        adr_src     = 1'b1;
        w_mem_write = 1'b1;
      end
      S_EXECR: begin
        alu_src_a = 2'b10;
        w_alu_op  = 2'b10;
      end
      S_EXECI: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        w_alu_op  = 2'b10;
      end
      S_ALUWB:    w_reg_write = 1'b1;
      S_BEQ: begin
        alu_src_a  = 2'b10;
        w_alu_op   = 2'b01;
        w_pc_write = zero;
      end
      S_JAL: begin
        alu_src_a  = 2'b01;
        alu_src_b  = 2'b10;
        w_pc_write = 1'b1;
      end
      S_TRAP:     illegal = 1'b1;
      default:    ;
    endcase
  end

  // Immediate type is decoded straight from the opcode.
  always_comb begin
    case (op)
      OP_SW:   imm_src = 2'b01;
      OP_BEQ:  imm_src = 2'b10;
      OP_JAL:  imm_src = 2'b11;
      default: imm_src = 2'b00;
    endcase
  end

  // ALU decoder: add for addresses and PC math, sub for beq, otherwise decode funct3.
  always_comb begin
    case (w_alu_op)
      2'b00:   w_alu_ctrl = 3'b000;
      2'b01:   w_alu_ctrl = 3'b001;
      default: begin
        case (funct3)
          3'b000:  w_alu_ctrl = (op[5] & funct7[5]) ? 3'b001 : 3'b000;
          3'b010:  w_alu_ctrl = 3'b101;
          3'b110:  w_alu_ctrl = 3'b011;
          3'b111:  w_alu_ctrl = 3'b010;
          default: w_alu_ctrl = 3'b000;
        endcase
      end
    endcase
  end

  assign alu_control = ALU_CTRL_W'(w_alu_ctrl);
  assign pc_write    = w_pc_write  & ~rst;
  assign ir_write    = w_ir_write  & ~rst;
  assign mem_write   = w_mem_write & ~rst;
  assign reg_write   = w_reg_write & ~rst;
  assign instret     = r_instret;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Randomized scoreboard bench for multicycle_control_unit.
// The driver walks each instruction through its phase list and queues the expected outputs.
// The monitor pops the queue at every falling edge and compares against the DUT.
module tb_multicycle_control_unit;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [6:0]  op = OP_LW;
  logic [2:0]  funct3 = 3'b000;
  logic [6:0]  funct7 = 7'b0;
  logic        zero = 1'b0;
  logic        mem_ready = 1'b0;
  logic        pc_write, adr_src, mem_write, ir_write, reg_write, illegal;
  logic [1:0]  result_src, alu_src_a, alu_src_b, imm_src;
  logic [2:0]  alu_control;
  logic [31:0] instret;

  multicycle_control_unit #(.ALU_CTRL_W(3), .HAS_MEM_HANDSHAKE(1'b1), .INSTRET_W(32)) dut (
    .clk(clk), .rst(rst), .op(op), .funct3(funct3), .funct7(funct7), .zero(zero),
    .mem_ready(mem_ready), .pc_write(pc_write), .adr_src(adr_src), .mem_write(mem_write),
    .ir_write(ir_write), .result_src(result_src), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .imm_src(imm_src), .reg_write(reg_write),
    .alu_control(alu_control), .illegal(illegal), .instret(instret)
  );

  always #5 clk = ~clk;

  // The phases an instruction passes through, in the order the datapath uses them.
  typedef enum {P_FETCH, P_DECODE, P_ADDR, P_LOAD, P_LOADWB, P_STORE,
                P_ALU_R, P_ALU_I, P_WB, P_BRANCH, P_JUMP, P_TRAP} phase_t;

  typedef struct packed {
    logic       pc_write, adr_src, mem_write, ir_write;
    logic [1:0] result_src, alu_src_a, alu_src_b, imm_src;
    logic       reg_write;
    logic [2:0] alu_control;
    logic       illegal;
  } outs_t;

  typedef struct {
    string       tag;
    outs_t       o;
    logic        chk_cnt;
    logic [31:0] cnt;
  } exp_t;

  exp_t        sb_q[$];
  int          n_checks = 0;
  int          n_pass   = 0;
  int          model_instret = 0;
  logic [6:0]  cur_op = OP_LW;
  logic [2:0]  cur_f3 = 3'b000;
  logic [6:0]  cur_f7 = 7'b0;
  logic        cur_zero = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act === expv) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
  endtask

  function automatic logic supported(input logic [6:0] o);
    return (o == OP_LW) || (o == OP_SW) || (o == OP_R) || (o == OP_I) ||
           (o == OP_BEQ) || (o == OP_JAL);
  endfunction

  function automatic logic [1:0] imm_ref(input logic [6:0] o);
    if (o == OP_SW)  return 2'b01;
    if (o == OP_BEQ) return 2'b10;
    if (o == OP_JAL) return 2'b11;
    return 2'b00;
  endfunction

  function automatic logic [2:0] funct_ref(input logic [6:0] o, input logic [2:0] f3,
                                           input logic [6:0] f7);
    case (f3)
      3'b000:  return (o[5] && f7[5]) ? 3'b001 : 3'b000;
      3'b010:  return 3'b101;
      3'b110:  return 3'b011;
      3'b111:  return 3'b010;
      default: return 3'b000;
    endcase
  endfunction

  // Expected outputs for one phase. ALU use is "add", "sub" or "funct-decoded".
  function automatic outs_t ref_outs(input phase_t p, input logic [6:0] o, input logic [2:0] f3,
                                     input logic [6:0] f7, input logic z, input logic rdy);
    outs_t r;
    int    kind;
    r = '0;
    kind = 0;
    r.imm_src = imm_ref(o);
    case (p)
      P_FETCH:  begin r.alu_src_b = 2'd2; r.result_src = 2'd2; r.ir_write = rdy; r.pc_write = rdy; end
      P_DECODE: begin r.alu_src_a = 2'd1; r.alu_src_b = 2'd1; end
      P_ADDR:   begin r.alu_src_a = 2'd2; r.alu_src_b = 2'd1; end
      P_LOAD:   r.adr_src = 1'b1;
      P_LOADWB: begin r.result_src = 2'd1; r.reg_write = 1'b1; end
      P_STORE:  begin r.adr_src = 1'b1; r.mem_write = 1'b1; end
      P_ALU_R:  begin r.alu_src_a = 2'd2; kind = 2; end
      P_ALU_I:  begin r.alu_src_a = 2'd2; r.alu_src_b = 2'd1; kind = 2; end
      P_WB:     r.reg_write = 1'b1;
      P_BRANCH: begin r.alu_src_a = 2'd2; kind = 1; r.pc_write = z; end
      P_JUMP:   begin r.alu_src_a = 2'd1; r.alu_src_b = 2'd2; r.pc_write = 1'b1; end
      P_TRAP:   r.illegal = 1'b1;
      default:  ;
    endcase
    r.alu_control = (kind == 1) ? 3'b001 : (kind == 2) ? funct_ref(o, f3, f7) : 3'b000;
    return r;
  endfunction

  // Drives one clock cycle of stimulus and queues the expected response.
  task automatic cycle(input phase_t p, input logic rdy, input logic rst_v, input string tag);
    exp_t e;
    @(posedge clk);
    #1;
    rst = rst_v; mem_ready = rdy; op = cur_op; funct3 = cur_f3; funct7 = cur_f7; zero = cur_zero;
    e.tag = tag;
    e.o = ref_outs(p, cur_op, cur_f3, cur_f7, cur_zero, rdy);
    if (rst_v) begin
      e.o.pc_write = 1'b0; e.o.ir_write = 1'b0; e.o.mem_write = 1'b0; e.o.reg_write = 1'b0;
    end
    e.chk_cnt = !rst_v;
    e.cnt = model_instret;
    sb_q.push_back(e);
  endtask

  task automatic do_reset();
    cycle(P_FETCH, 1'($urandom_range(0, 1)), 1'b1, "reset");
    model_instret = 0;
  endtask

  // Runs one instruction from fetch to retirement, or to a trap/abort.
  task automatic run_instr(input logic [6:0] o, input logic [2:0] f3, input logic [6:0] f7,
                           input logic z, input int fst, input int mst, input int trap_hold,
                           input bit abort_store);
    cur_op = o; cur_f3 = f3; cur_f7 = f7; cur_zero = z;
    for (int i = 0; i < fst; i++) cycle(P_FETCH, 1'b0, 1'b0, "fetch_wait");
    cycle(P_FETCH, 1'b1, 1'b0, "fetch");
    if (!supported(o)) begin
      for (int i = 0; i < trap_hold; i++) cycle(P_TRAP, 1'($urandom_range(0, 1)), 1'b0, "trap");
      do_reset();
      return;
    end
    cycle(P_DECODE, 1'($urandom_range(0, 1)), 1'b0, "decode");
    if (o == OP_LW) begin
      cycle(P_ADDR, 1'($urandom_range(0, 1)), 1'b0, "lw_addr");
      for (int i = 0; i < mst; i++) cycle(P_LOAD, 1'b0, 1'b0, "lw_wait");
      cycle(P_LOAD, 1'b1, 1'b0, "lw_read");
      cycle(P_LOADWB, 1'($urandom_range(0, 1)), 1'b0, "lw_wb");
    end else if (o == OP_SW) begin
      cycle(P_ADDR, 1'($urandom_range(0, 1)), 1'b0, "sw_addr");
      if (abort_store) begin
        cycle(P_STORE, 1'b0, 1'b0, "sw_hold");
        do_reset();
        return;
      end
      for (int i = 0; i < mst; i++) cycle(P_STORE, 1'b0, 1'b0, "sw_wait");
      cycle(P_STORE, 1'b1, 1'b0, "sw_write");
    end else if (o == OP_R || o == OP_I) begin
      cycle((o == OP_R) ? P_ALU_R : P_ALU_I, 1'($urandom_range(0, 1)), 1'b0, "exec");
      cycle(P_WB, 1'($urandom_range(0, 1)), 1'b0, "alu_wb");
    end else if (o == OP_BEQ) begin
      cycle(P_BRANCH, 1'($urandom_range(0, 1)), 1'b0, "beq");
    end else begin
      cycle(P_JUMP, 1'($urandom_range(0, 1)), 1'b0, "jal");
      cycle(P_WB, 1'($urandom_range(0, 1)), 1'b0, "jal_wb");
    end
    model_instret++;
  endtask

  // Monitor: compare each cycle's DUT outputs against the queued expectation.
  exp_t  mon_e;
  outs_t mon_a;
  always @(negedge clk) begin
    if (sb_q.size() > 0) begin
      mon_e = sb_q.pop_front();
      mon_a = {pc_write, adr_src, mem_write, ir_write, result_src, alu_src_a, alu_src_b,
               imm_src, reg_write, alu_control, illegal};
      check({mon_e.tag, "_outs"}, 32'(mon_a), 32'(mon_e.o));
      if (mon_e.chk_cnt) check({mon_e.tag, "_instret"}, instret, mon_e.cnt);
    end
  end

  logic [6:0] ops_tab [6];
  logic [6:0] bad_op;

  initial begin
    ops_tab[0] = OP_LW; ops_tab[1] = OP_SW; ops_tab[2] = OP_R;
    ops_tab[3] = OP_I;  ops_tab[4] = OP_BEQ; ops_tab[5] = OP_JAL;
    do_reset();
    // Directed sequences, one for each scenario of interest.
    run_instr(OP_LW,  3'b010, 7'h00, 1'b0, 2, 3, 0, 1'b0);
    run_instr(OP_R,   3'b000, 7'h20, 1'b0, 0, 0, 0, 1'b0);
    run_instr(OP_BEQ, 3'b000, 7'h00, 1'b1, 0, 0, 0, 1'b0);
    run_instr(OP_BEQ, 3'b000, 7'h00, 1'b0, 0, 0, 0, 1'b0);
    run_instr(OP_JAL, 3'b000, 7'h00, 1'b0, 0, 0, 0, 1'b0);
    run_instr(OP_I,   3'b000, 7'h20, 1'b0, 1, 0, 0, 1'b0);
    run_instr(7'b1111111, 3'b000, 7'h00, 1'b0, 0, 0, 10, 1'b0);
    run_instr(OP_SW,  3'b010, 7'h00, 1'b0, 0, 0, 0, 1'b1);
    run_instr(OP_R,   3'b111, 7'h00, 1'b0, 0, 0, 0, 1'b0);
    // Random mix of instructions, stalls, traps and aborted stores.
    for (int n = 0; n < 200; n++) begin
      int k;
      k = $urandom_range(0, 9);
      if (k == 8) begin
        do bad_op = 7'($urandom); while (supported(bad_op));
        run_instr(bad_op, 3'($urandom), 7'($urandom), 1'($urandom), $urandom_range(0, 2),
                  0, $urandom_range(1, 6), 1'b0);
      end else if (k == 9) begin
        run_instr(OP_SW, 3'($urandom), 7'($urandom), 1'($urandom), $urandom_range(0, 2),
                  0, 0, 1'b1);
      end else begin
        run_instr(ops_tab[(k > 5) ? k - 6 : k], 3'($urandom), 7'($urandom), 1'($urandom),
                  $urandom_range(0, 3), $urandom_range(0, 3), 0, 1'b0);
      end
    end
    @(posedge clk);
    @(posedge clk);
    check("scoreboard_drained", 32'(sb_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
